// File: rtl/addsub_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
package addsub_pkg;

  localparam int   SLICE    = 4;
  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_seq_slice.sv
// Combinational 4-bit add/sub slice; subtract inverts b and relies on the caller's carry-in.
module add_sub_slice
  import addsub_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             mode,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [SLICE-1:0] b_eff;
  logic [SLICE-1:0] low;
  logic [1:0]       top;

  assign b_eff = (mode == MODE_ADD) ? b : ~b;

  // Split at the top bit so the carry into it is visible for signed overflow.
  assign low      = {1'b0, a[SLICE-2:0]} + {1'b0, b_eff[SLICE-2:0]} + {{(SLICE-1){1'b0}}, cin};
  assign c_msb_in = low[SLICE-1];
  assign top      = {1'b0, a[SLICE-1]} + {1'b0, b_eff[SLICE-1]} + {1'b0, c_msb_in};
  assign sum      = {top[0], low[SLICE-2:0]};
  assign cout     = top[1];

endmodule

// File: rtl/addsub_seq.sv
// WIDTH-bit adder/subtractor that reuses one 4-bit slice, least-significant nibble first.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             mode,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             done,
  output logic             busy
);

  // WIDTH must be a multiple of SLICE and at least two slices wide.
  localparam int              N      = WIDTH / SLICE;
  localparam int              KW     = $clog2(N);
  localparam logic [KW-1:0]   K_LAST = KW'(N - 1);

  state_t           state, state_nxt;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_r, b_r;
  logic             mode_r;
  logic             cy_r;
  logic             accept;
  logic [SLICE-1:0] s_a, s_b, s_sum;
  logic             s_cout, s_cmsb;

  assign start_ready = (state == IDLE) && !rst;
  assign accept      = start_valid && start_ready;
  assign done        = (state == DONE);
  assign busy        = (state != IDLE);

  assign s_a = a_r[int'(k)*SLICE +: SLICE];
  assign s_b = b_r[int'(k)*SLICE +: SLICE];

  add_sub_slice u_slice (
    .a        (s_a),
    .b        (s_b),
    .mode     (mode_r),
    .cin      (cy_r),
    .sum      (s_sum),
    .cout     (s_cout),
    .c_msb_in (s_cmsb)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (k == K_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand latches carry no reset: they are only read after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r    <= a_in;
      b_r    <= b_in;
      mode_r <= mode;
    end
  end

  // Result is overwritten nibble by nibble; flags only move on the last slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      k        <= '0;
      cy_r     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      k    <= '0;
      cy_r <= ~mode;
    end else if (state == RUN) begin
      result[int'(k)*SLICE +: SLICE] <= s_sum;
      cy_r <= s_cout;
      k    <= k + 1'b1;
      if (k == K_LAST) begin
        carry    <= s_cout;
        overflow <= s_cmsb ^ s_cout;
      end
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench: timeline/arithmetic reference model plus directed literal vectors.
module tb_addsub_seq;

  localparam int N = 4;

  logic        clk, rst, start_valid, start_ready, mode;
  logic [15:0] a_in, b_in, result;
  logic        carry, overflow, done, busy;

  int n_checks = 0;
  int n_fail   = 0;

  addsub_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .a_in(a_in), .b_in(b_in), .mode(mode), .result(result), .carry(carry),
    .overflow(overflow), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string nm, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check16(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %04h expected %04h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference arithmetic: {overflow, carry, result}.
  function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b, input logic m);
    logic [16:0] s;
    logic        v;
    if (m) s = {1'b0, a} + {1'b0, b};
    else   s = {1'b0, a} + {1'b0, ~b} + 17'd1;
    if (m) v = (a[15] == b[15]) && (s[15] != a[15]);
    else   v = (a[15] != b[15]) && (s[15] != a[15]);
    return {v, s};
  endfunction

  // Timeline model: an accepted op is busy for N+1 cycles, done on the last.
  logic        mon_en = 1'b0;
  logic        m_act  = 1'b0;
  int          m_age  = 0;
  logic [17:0] pend   = '0;
  logic [15:0] m_res  = '0;
  logic        m_c    = 1'b0;
  logic        m_v    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mon_en = 1'b1;
      m_act  = 1'b0;
      m_age  = 0;
      m_res  = '0;
      m_c    = 1'b0;
      m_v    = 1'b0;
    end else if (m_act) begin
      m_age++;
      if (m_age == N) {m_v, m_c, m_res} = pend;
      else if (m_age == N + 1) m_act = 1'b0;
    end else if (start_valid) begin
      pend  = ref_op(a_in, b_in, mode);
      m_act = 1'b1;
      m_age = 0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check1("start_ready", start_ready, !m_act && !rst);
      check1("done", done, m_act && (m_age == N));
      check1("busy", busy, m_act);
      if (!(m_act && m_age < N)) begin
        check16("result", result, m_res);
        check1("carry", carry, m_c);
        check1("overflow", overflow, m_v);
      end
    end
  end

  // Present an op, hold it until accepted, then scramble the inputs.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic m, output logic ok);
    int w;
    @(posedge clk); #2;
    a_in = a; b_in = b; mode = m; start_valid = 1'b1;
    w = 0;
    while (!start_ready && w < 20) begin
      @(posedge clk); #2;
      w++;
    end
    ok = start_ready;
    if (!ok) begin
      check1("accept_timeout", 1'b0, 1'b1);
      start_valid = 1'b0;
      return;
    end
    @(posedge clk); #2;
    start_valid = 1'b0;
    a_in = 16'($urandom);
    b_in = 16'($urandom);
    mode = ~m;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic m,
                        input logic [15:0] er, input logic ec, input logic ev);
    int   lat;
    logic ok;
    issue(a, b, m, ok);
    if (!ok) return;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 12);
    check16("latency", 16'(lat - 1), 16'd4);
    check16("op_result", result, er);
    check1("op_carry", carry, ec);
    check1("op_overflow", overflow, ev);
    check1("ready_low_in_done", start_ready, 1'b0);
    @(negedge clk);
    check1("ready_return", start_ready, 1'b1);
    check1("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    int   ndone, last_c;
    logic ok;
    rst = 1'b1; start_valid = 1'b0; a_in = '0; b_in = '0; mode = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check1("rst_ready", start_ready, 1'b0);
    check16("rst_result", result, 16'h0000);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_carry", carry, 1'b0);
    check1("rst_overflow", overflow, 1'b0);
    // Accept attempt under reset is refused.
    start_valid = 1'b1; a_in = 16'h1111; b_in = 16'h2222;
    @(posedge clk); #2;
    start_valid = 1'b0;
    check1("rst_wins_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check1("ready_after_rst", start_ready, 1'b1);

    run_op(16'h1234, 16'h0FFF, 1'b1, 16'h2233, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0009, 1'b0, 16'hFFFC, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    run_op(16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1);

    // start_valid held high with operands changing every cycle.
    @(posedge clk); #2;
    start_valid = 1'b1;
    ndone = 0; last_c = -1;
    for (int c = 0; c < 26; c++) begin
      a_in = 16'(16'h1357 * c + 16'h0101);
      b_in = 16'(16'h0F0F ^ (c * 16'h0111));
      mode = c[0];
      @(negedge clk);
      if (done) begin
        ndone++;
        if (last_c >= 0) check16("accept_interval", 16'(c - last_c), 16'd6);
        last_c = c;
      end
      @(posedge clk); #2;
    end
    start_valid = 1'b0;
    check16("held_done_count", 16'(ndone), 16'd4);

    // Reset during the second RUN cycle abandons the op.
    issue(16'h00FF, 16'h0001, 1'b1, ok);
    if (ok) begin
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      check1("abort_busy", busy, 1'b0);
      check16("abort_result", result, 16'h0000);
      check1("abort_carry", carry, 1'b0);
      check1("abort_done", done, 1'b0);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        check1("abort_no_done", done, 1'b0);
      end
    end
    run_op(16'h0003, 16'h0003, 1'b0, 16'h0000, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
